norm_writer: RTL and testbench

// Producer side of the normalisation handshake. Sits between the crop filter output and the

---
 rtl/norm_writer_pkg.sv | 9 +
 rtl/norm_writer_if.sv | 14 +
 rtl/norm_writer_reg_slice.sv | 58 +++++
 rtl/norm_writer.sv | 132 +++++++++++++
 tb/tb_norm_writer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/norm_writer_pkg.sv
// Shared types and constants for the normalisation writer: FSM encoding, pixel type
// and the minimum legal denominator.
package norm_pkg;
  localparam int PKG_PIXEL_BIT_WIDTH = 10;
  localparam int MIN_DENOM           = 1;

  typedef logic [PKG_PIXEL_BIT_WIDTH-1:0] pixel_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} norm_wr_state_t;
endpackage

// File: rtl/norm_writer_if.sv
// AXI4-Stream style bus (valid/ready/data/user/last) used on both sides of the writer.
interface norm_writer_if #(
  parameter int DATA_W = 10,
  parameter int USER_W = 2
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [USER_W-1:0] tuser;
  logic              tlast;

  modport master (output tvalid, tdata, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/norm_writer_reg_slice.sv
// Single-stage forward register slice: the load strobe captures a beat, which is held
// until the downstream ready retires it.
module axis_reg_slice #(
  parameter int DATA_W = 10,
  parameter int USER_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic [USER_W-1:0] in_user,
  input  logic              in_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [USER_W-1:0] out_user,
  output logic              out_last
);
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [USER_W-1:0] user_q, user_d;
  logic              last_q, last_d;

  // load is only raised when the slot is empty or being emptied this cycle
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    user_d  = user_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      user_d  = in_user;
      last_d  = in_last;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      user_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      user_q  <= user_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_user  = user_q;
  assign out_last  = last_q;
endmodule

// File: rtl/norm_writer.sv
// Forwards the cropped pixel stream through a register slice while tracking the frame peak,
// then publishes the peak as the normaliser denominator and pulses ap_done.
module norm_writer
  import norm_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int USER_WIDTH      = 2,
  parameter int CNT_WIDTH       = 24
) (
  input  logic                       clk,
  input  logic                       s_axis_resetn,
  input  logic                       ap_start,
  output logic                       ap_done,
  output logic                       ap_idle,
  output logic                       ap_ready,
  input  logic [CNT_WIDTH-1:0]       num_pixels,
  norm_writer_if.slave               s_axis,
  norm_writer_if.master              m_axis,
  output logic [PIXEL_BIT_WIDTH-1:0] norm_denominator,
  output logic                       frame_err
);
  localparam logic [PIXEL_BIT_WIDTH-1:0] DENOM_FLOOR = PIXEL_BIT_WIDTH'(MIN_DENOM);

  norm_wr_state_t              state_q, state_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]        npix_q, npix_d;
  logic [PIXEL_BIT_WIDTH-1:0]  peak_q, peak_d;
  logic [PIXEL_BIT_WIDTH-1:0]  denom_q, denom_d;
  logic                        ferr_q, ferr_d;

  logic                        s_accept;
  logic                        cnt_match;
  logic                        final_beat;
  logic [PIXEL_BIT_WIDTH-1:0]  peak_new;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  function automatic logic [PIXEL_BIT_WIDTH-1:0] denom_guard(
    input logic [PIXEL_BIT_WIDTH-1:0] p);
    return (p == '0) ? DENOM_FLOOR : p;
  endfunction

  assign s_axis.tready = (state_q == RUN) && (!m_axis.tvalid || m_axis.tready);
  assign s_accept      = s_axis.tvalid && s_axis.tready;
  // npix_q is never 0 in RUN, so the subtraction cannot underflow
  assign cnt_match     = (cnt_q == npix_q - CNT_WIDTH'(1));
  assign final_beat    = s_accept && (s_axis.tlast || cnt_match);
  assign peak_new      = (s_axis.tdata > peak_q) ? s_axis.tdata : peak_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    npix_d  = npix_q;
    peak_d  = peak_q;
    denom_d = denom_q;
    ferr_d  = ferr_q;
    case (state_q)
      IDLE: begin
        if (ap_start) begin
          npix_d = num_pixels;
          cnt_d  = '0;
          peak_d = '0;
          ferr_d = 1'b0;
          if (num_pixels == '0) begin
            denom_d = DENOM_FLOOR;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (s_accept) begin
          cnt_d  = sat_inc(cnt_q);
          peak_d = peak_new;
          if (final_beat) begin
            denom_d = denom_guard(peak_new);
            ferr_d  = ferr_q | (s_axis.tlast != cnt_match);
            state_d = DRAIN;
          end
        end
      end
      DRAIN:   if (!m_axis.tvalid || m_axis.tready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      npix_q  <= '0;
      peak_q  <= '0;
      denom_q <= DENOM_FLOOR;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      npix_q  <= npix_d;
      peak_q  <= peak_d;
      denom_q <= denom_d;
      ferr_q  <= ferr_d;
    end
  end

  // the final beat always leaves the slice flagged as frame end
  axis_reg_slice #(
    .DATA_W (PIXEL_BIT_WIDTH),
    .USER_W (USER_WIDTH)
  ) u_slice (
    .clk       (clk),
    .rst_n     (s_axis_resetn),
    .load      (s_accept),
    .in_data   (s_axis.tdata),
    .in_user   (s_axis.tuser),
    .in_last   (s_axis.tlast || cnt_match),
    .out_ready (m_axis.tready),
    .out_valid (m_axis.tvalid),
    .out_data  (m_axis.tdata),
    .out_user  (m_axis.tuser),
    .out_last  (m_axis.tlast)
  );

  assign ap_done          = (state_q == DONE);
  assign ap_idle          = (state_q == IDLE);
  assign ap_ready         = (state_q == IDLE);
  assign norm_denominator = denom_q;
  assign frame_err        = ferr_q;
endmodule

// File: tb/tb_norm_writer.sv
// Directed bench for norm_writer: frame forwarding, peak denominator, frame-end handling,
// stalls, reset mid-frame and ap_start handling.
module tb_norm_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ap_start = 1'b0;
  logic [23:0] num_pixels = '0;
  logic        ap_done, ap_idle, ap_ready, frame_err;
  logic [9:0]  norm_denominator;

  norm_writer_if #(.DATA_W(10), .USER_W(2)) s_if ();
  norm_writer_if #(.DATA_W(10), .USER_W(2)) m_if ();

  norm_writer #(.PIXEL_BIT_WIDTH(10), .USER_WIDTH(2), .CNT_WIDTH(24)) dut (
    .clk              (clk),
    .s_axis_resetn    (rst_n),
    .ap_start         (ap_start),
    .ap_done          (ap_done),
    .ap_idle          (ap_idle),
    .ap_ready         (ap_ready),
    .num_pixels       (num_pixels),
    .s_axis           (s_if),
    .m_axis           (m_if),
    .norm_denominator (norm_denominator),
    .frame_err        (frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // master-side monitor: {tuser, tlast, tdata} per handshake
  logic [12:0] obs_q[$];
  int          hs_cnt = 0, done_cnt = 0, hs_at_done = 0, stab_bad = 0;
  logic        stall_mode = 1'b0;
  logic [1:0]  phase = 2'd0;
  logic        stalled_q = 1'b0;
  logic [9:0]  prev_data = '0;
  logic        prev_last = 1'b0;

  assign m_if.tready = stall_mode ? (phase == 2'd0) : 1'b1;
  always @(negedge clk) phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;

  always @(posedge clk) begin
    if (m_if.tvalid && m_if.tready) begin
      obs_q.push_back({m_if.tuser, m_if.tlast, m_if.tdata});
      hs_cnt <= hs_cnt + 1;
    end
    if (ap_done) begin
      done_cnt   <= done_cnt + 1;
      hs_at_done <= hs_cnt;
    end
    if (rst_n && stalled_q &&
        !(m_if.tvalid && m_if.tdata == prev_data && m_if.tlast == prev_last))
      stab_bad <= stab_bad + 1;
    stalled_q <= rst_n && m_if.tvalid && !m_if.tready;
    prev_data <= m_if.tdata;
    prev_last <= m_if.tlast;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] beat(input int idx);
    return (obs_q.size() > idx) ? obs_q[idx] : 13'h1fff;
  endfunction

  task automatic start(input logic [23:0] n);
    @(negedge clk); ap_start = 1'b1; num_pixels = n;
    @(negedge clk); ap_start = 1'b0;
  endtask

  task automatic send(input logic [9:0] d, input logic l, input int budget, output bit acc);
    @(negedge clk);
    s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tlast = l; s_if.tuser = d[1:0];
    acc = 1'b0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (s_if.tready) begin
        acc = 1'b1;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle_bus();
    @(negedge clk); s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp, input int budget);
    for (int i = 0; i < budget && done_cnt < exp; i++) @(negedge clk);
    chk({tag, "_done_seen"}, done_cnt, exp);
    repeat (3) @(negedge clk);
    chk({tag, "_done_once"}, done_cnt, exp);
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [9:0] d, input logic l);
    logic [12:0] b;
    b = beat(idx);
    chk({tag, "_data"}, b[9:0], d);
    chk({tag, "_last"}, b[10], l);
    chk({tag, "_user"}, b[12:11], d[1:0]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ap_done"}, ap_done, 1'b0);
    chk({tag, "_ap_idle"}, ap_idle, 1'b1);
    chk({tag, "_ap_ready"}, ap_ready, 1'b1);
    chk({tag, "_s_tready"}, s_if.tready, 1'b0);
    chk({tag, "_m_tvalid"}, m_if.tvalid, 1'b0);
    chk({tag, "_m_tdata"}, m_if.tdata, 10'd0);
    chk({tag, "_m_tuser"}, m_if.tuser, 2'd0);
    chk({tag, "_m_tlast"}, m_if.tlast, 1'b0);
    chk({tag, "_denom"}, norm_denominator, 10'd1);
    chk({tag, "_ferr"}, frame_err, 1'b0);
  endtask

  initial begin
    bit acc;
    int base, hs_base, exp_done;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
    exp_done = 0;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_reset_outputs("por");
    @(negedge clk) rst_n = 1'b1;

    // frame 1: 3,9,7,2 with tlast on beat 4, no stalls
    base = obs_q.size(); hs_base = hs_cnt;
    start(24'd4);
    chk("f1_idle_in_run", ap_idle, 1'b0);
    chk("f1_ready_in_run", ap_ready, 1'b0);
    send(10'd3, 1'b0, 20, acc); send(10'd9, 1'b0, 20, acc);
    send(10'd7, 1'b0, 20, acc); send(10'd2, 1'b1, 20, acc);
    idle_bus();
    exp_done++; wait_done("f1", exp_done, 20);
    chk("f1_beats", obs_q.size() - base, 4);
    chk_beat("f1_b0", base, 10'd3, 1'b0); chk_beat("f1_b1", base + 1, 10'd9, 1'b0);
    chk_beat("f1_b2", base + 2, 10'd7, 1'b0); chk_beat("f1_b3", base + 3, 10'd2, 1'b1);
    chk("f1_denom", norm_denominator, 10'd9);
    chk("f1_ferr", frame_err, 1'b0);
    chk("f1_done_after_hs", hs_at_done - hs_base, 4);

    // frame 2: same frame with master stalls
    stall_mode = 1'b1;
    base = obs_q.size(); hs_base = hs_cnt;
    start(24'd4);
    send(10'd3, 1'b0, 20, acc); send(10'd9, 1'b0, 20, acc);
    send(10'd7, 1'b0, 20, acc); send(10'd2, 1'b1, 20, acc);
    idle_bus();
    exp_done++; wait_done("f2", exp_done, 40);
    stall_mode = 1'b0;
    chk("f2_beats", obs_q.size() - base, 4);
    chk_beat("f2_b0", base, 10'd3, 1'b0); chk_beat("f2_b1", base + 1, 10'd9, 1'b0);
    chk_beat("f2_b2", base + 2, 10'd7, 1'b0); chk_beat("f2_b3", base + 3, 10'd2, 1'b1);
    chk("f2_denom", norm_denominator, 10'd9);
    chk("f2_done_after_hs", hs_at_done - hs_base, 4);
    chk("f2_stall_stable", stab_bad, 0);

    // frame 3: early tlast on beat 2 of 4
    base = obs_q.size();
    start(24'd4);
    send(10'd5, 1'b0, 20, acc); send(10'd6, 1'b1, 20, acc);
    idle_bus();
    exp_done++; wait_done("f3", exp_done, 20);
    chk("f3_beats", obs_q.size() - base, 2);
    chk_beat("f3_b1", base + 1, 10'd6, 1'b1);
    chk("f3_denom", norm_denominator, 10'd6);
    chk("f3_ferr", frame_err, 1'b1);

    // frame 4: count reaches 3 without tlast, a 4th beat must be refused
    base = obs_q.size();
    start(24'd3);
    chk("f4_ferr_cleared", frame_err, 1'b0);
    send(10'd1, 1'b0, 20, acc); send(10'd2, 1'b0, 20, acc); send(10'd3, 1'b0, 20, acc);
    send(10'd4, 1'b0, 6, acc);
    chk("f4_extra_refused", acc, 1'b0);
    idle_bus();
    exp_done++; wait_done("f4", exp_done, 20);
    chk("f4_beats", obs_q.size() - base, 3);
    chk_beat("f4_b2", base + 2, 10'd3, 1'b1);
    chk("f4_denom", norm_denominator, 10'd3);
    chk("f4_ferr", frame_err, 1'b1);

    // reset after 2 of 4 beats: slice and partial peak discarded, no ap_done
    start(24'd4);
    send(10'd10, 1'b0, 20, acc); send(10'd20, 1'b0, 20, acc);
    @(negedge clk); rst_n = 1'b0; s_if.tvalid = 1'b0;
    #1 chk_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_cnt, exp_done);

    // frame after reset: 1,1023
    start(24'd2);
    send(10'd1, 1'b0, 20, acc); send(10'd1023, 1'b1, 20, acc);
    idle_bus();
    exp_done++; wait_done("f5", exp_done, 20);
    chk("f5_denom", norm_denominator, 10'd1023);

    // all-zero frame: denominator floored to 1
    start(24'd2);
    send(10'd0, 1'b0, 20, acc); send(10'd0, 1'b1, 20, acc);
    idle_bus();
    exp_done++; wait_done("f6", exp_done, 20);
    chk("f6_denom", norm_denominator, 10'd1);
    chk("f6_ferr", frame_err, 1'b0);

    // ap_start pulsed mid-frame is ignored; frame peaks 8 then 4 back to back
    base = obs_q.size();
    start(24'd2);
    send(10'd8, 1'b0, 20, acc);
    @(negedge clk); s_if.tvalid = 1'b0; ap_start = 1'b1; num_pixels = 24'd5;
    #1 chk("f7_ready_in_run", ap_ready, 1'b0);
    @(negedge clk); ap_start = 1'b0;
    send(10'd3, 1'b1, 20, acc);
    idle_bus();
    exp_done++; wait_done("f7", exp_done, 20);
    chk("f7_beats", obs_q.size() - base, 2);
    chk_beat("f7_b1", base + 1, 10'd3, 1'b1);
    chk("f7_denom", norm_denominator, 10'd8);
    chk("f7_ferr", frame_err, 1'b0);
    start(24'd2);
    chk("f8_denom_held", norm_denominator, 10'd8);
    send(10'd4, 1'b0, 20, acc); send(10'd1, 1'b1, 20, acc);
    idle_bus();
    exp_done++; wait_done("f8", exp_done, 20);
    chk("f8_denom", norm_denominator, 10'd4);

    // empty frame: straight to done, nothing accepted
    hs_base = hs_cnt;
    start(24'd0);
    chk("f9_s_tready", s_if.tready, 1'b0);
    exp_done++; wait_done("f9", exp_done, 2);
    chk("f9_no_beats", hs_cnt - hs_base, 0);
    chk("f9_denom", norm_denominator, 10'd1);
    chk("f9_ferr", frame_err, 1'b0);
    chk("end_idle", ap_idle, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
